tdp_ram_be: RTL and testbench

- Single-clock true dual-port RAM; successor to the team's basic dual-port RAM.
- Adds per-byte write enables, a selectable read-during-write mode, an optional output register stage, and per-port read-valid strobes.
- Adds cross-port collision detection and a post-reset memory-clear sweep.
- Sits behind the UART TX/RX buffering and register-file logic wherever two agents share one storage array.

---
 rtl/tdp_ram_pkg.sv | 14 +
 rtl/tdp_ram_port.sv | 76 +++++++
 rtl/tdp_ram_be.sv | 107 ++++++++++
 tb/tb_tdp_ram_be.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdp_ram_pkg.sv
// Shared constants for the byte-enable true dual-port RAM.
// Read-during-write mode codes and the init sequencer state encoding.
package tdp_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/tdp_ram_port.sv
// Per-port read path: RDW select, out-of-range zeroing, optional output register.
// Latency 1 (OUT_REG=0) or 2 (OUT_REG=1); no backpressure, one result per accepted cycle.
module tdp_ram_port
    import tdp_ram_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int BYTE_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0,
    localparam int NB      = WIDTH / BYTE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc,
    input  logic [NB-1:0]    we,
    input  logic             in_range,
    input  logic [WIDTH-1:0] rd_word,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rd_sel;
    logic [WIDTH-1:0] d1;
    logic             v1;
    logic             wr_hit;

    // Out-of-range writes are dropped upstream, so they never count as a write here.
    assign wr_hit = in_range && (|we);

    always_comb begin
        merged = rd_word;
        for (int k = 0; k < NB; k++) begin
            if (we[k]) merged[k*BYTE_W +: BYTE_W] = din[k*BYTE_W +: BYTE_W];
        end
        rd_sel = rd_word;
        if (!in_range) rd_sel = '0;
        else if (RDW_MODE == RDW_WRITE_FIRST && wr_hit) rd_sel = merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else if (acc && !(RDW_MODE == RDW_NO_CHANGE && wr_hit)) begin
            d1 <= rd_sel;
            v1 <= 1'b1;
        end else begin
            v1 <= 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] d2;
            logic             v2;
            // d1 holds when idle, so tracking it unconditionally keeps dout held too.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    d2 <= d1;
                    v2 <= v1;
                end
            end
            assign dout  = d2;
            assign valid = v2;
        end else begin : g_noreg
            assign dout  = d1;
            assign valid = v1;
        end
    endgenerate

endmodule

// File: rtl/tdp_ram_be.sv
// Single-clock true dual-port RAM with byte enables, collision strobe and post-reset clear.
// Read latency 1 or 2 (OUT_REG); no backpressure, ports ignored until init_done.
module tdp_ram_be
    import tdp_ram_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int BYTE_W     = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int CLR_ON_RST = 1,
    localparam int NB        = WIDTH / BYTE_W,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             init_done,
    input  logic             ena,
    input  logic [NB-1:0]    wea,
    input  logic [AW-1:0]    addra,
    input  logic [WIDTH-1:0] dina,
    output logic [WIDTH-1:0] douta,
    output logic             valida,
    input  logic             enb,
    input  logic [NB-1:0]    web,
    input  logic [AW-1:0]    addrb,
    input  logic [WIDTH-1:0] dinb,
    output logic [WIDTH-1:0] doutb,
    output logic             validb,
    output logic             collision
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    logic [AW-1:0]    clr_addr;
    logic             ready;
    logic             clr_we;
    logic             a_inr;
    logic             b_inr;
    logic [NB-1:0]    wla;
    logic [NB-1:0]    wlb;
    logic [WIDTH-1:0] rda;
    logic [WIDTH-1:0] rdb;

    assign ready     = (state == READY);
    assign init_done = ready;
    assign clr_we    = rst_n && !ready && (CLR_ON_RST != 0);
    assign a_inr     = ({1'b0, addra} < DEPTH_C);
    assign b_inr     = ({1'b0, addrb} < DEPTH_C);
    assign wla       = (ena && ready && a_inr) ? wea : '0;
    assign wlb       = (enb && ready && b_inr) ? web : '0;
    assign rda       = a_inr ? mem[addra] : '0;
    assign rdb       = b_inr ? mem[addrb] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (CLR_ON_RST == 0 || clr_addr == LAST_ADDR) state <= READY;
                    else clr_addr <= clr_addr + AW'(1);
                end
                default: state <= READY;
            endcase
        end
    end

    // Port B lanes are applied last so B wins any lane both ports enable.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (wla[k]) mem[addra][k*BYTE_W +: BYTE_W] <= dina[k*BYTE_W +: BYTE_W];
            end
            for (int k = 0; k < NB; k++) begin
                if (wlb[k]) mem[addrb][k*BYTE_W +: BYTE_W] <= dinb[k*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) collision <= 1'b0;
        else collision <= ready && ena && enb && a_inr && b_inr &&
                          (addra == addrb) && ((|wea) || (|web));
    end

    tdp_ram_port #(
        .WIDTH(WIDTH), .BYTE_W(BYTE_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
    ) u_port_a (
        .clk(clk), .rst_n(rst_n), .acc(ena && ready), .we(wea), .in_range(a_inr),
        .rd_word(rda), .din(dina), .dout(douta), .valid(valida)
    );

    tdp_ram_port #(
        .WIDTH(WIDTH), .BYTE_W(BYTE_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
    ) u_port_b (
        .clk(clk), .rst_n(rst_n), .acc(enb && ready), .we(web), .in_range(b_inr),
        .rd_word(rdb), .din(dinb), .dout(doutb), .valid(validb)
    );

endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: five instances share one stimulus bus, differing in
// RDW mode, output register and depth (index 4 has DEPTH 12 for out-of-range).
module tb_tdp_ram_be;

    localparam int W  = 16;
    localparam int NB = 2;
    localparam int AW = 4;
    localparam int N  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          ena, enb;
    logic [NB-1:0] wea, web;
    logic [AW-1:0] addra, addrb;
    logic [W-1:0]  dina, dinb;
    logic [W-1:0]  douta [N];
    logic [W-1:0]  doutb [N];
    logic          valida [N];
    logic          validb [N];
    logic          coll [N];
    logic          idone [N];

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] q3[$];
    logic [W-1:0] qb[$];

    tdp_ram_be #(.WIDTH(W), .DEPTH(16), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_rf (
        .clk(clk), .rst_n(rst_n), .init_done(idone[0]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[0]), .valida(valida[0]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[0]), .validb(validb[0]),
        .collision(coll[0]));
    tdp_ram_be #(.WIDTH(W), .DEPTH(16), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(0), .CLR_ON_RST(1)) u_wf (
        .clk(clk), .rst_n(rst_n), .init_done(idone[1]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[1]), .valida(valida[1]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[1]), .validb(validb[1]),
        .collision(coll[1]));
    tdp_ram_be #(.WIDTH(W), .DEPTH(16), .BYTE_W(8), .RDW_MODE(2), .OUT_REG(0), .CLR_ON_RST(1)) u_nc (
        .clk(clk), .rst_n(rst_n), .init_done(idone[2]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[2]), .valida(valida[2]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[2]), .validb(validb[2]),
        .collision(coll[2]));
    tdp_ram_be #(.WIDTH(W), .DEPTH(16), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(1), .CLR_ON_RST(1)) u_or (
        .clk(clk), .rst_n(rst_n), .init_done(idone[3]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[3]), .valida(valida[3]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[3]), .validb(validb[3]),
        .collision(coll[3]));
    tdp_ram_be #(.WIDTH(W), .DEPTH(12), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_np2 (
        .clk(clk), .rst_n(rst_n), .init_done(idone[4]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[4]), .valida(valida[4]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[4]), .validb(validb[4]),
        .collision(coll[4]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] ad,
                         input logic [W-1:0] d);
        ena = en; wea = we; addra = ad; dina = d;
    endtask

    task automatic set_b(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] ad,
                         input logic [W-1:0] d);
        enb = en; web = we; addrb = ad; dinb = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_a(1'b1, 2'b00, 4'd3, 16'h0);
        set_b(1'b0, 2'b00, 4'd0, 16'h0);
        repeat (3) tick();
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if ({idone[i], valida[i], validb[i], coll[i]} !== 4'b0000 ||
                douta[i] !== 16'h0 || doutb[i] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: init/va/vb/coll=%b%b%b%b douta=%h doutb=%h, need all zero",
                         i, idone[i], valida[i], validb[i], coll[i], douta[i], doutb[i]);
            end
        end
    endtask

    task automatic test_clear();
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            n_tests++;
            if (idone[0] !== (c == 16) || valida[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL clear cycle %0d: init_done=%b valida=%b, need init_done=%b valida=0",
                         c, idone[0], valida[0], (c == 16));
            end
            if (c == 11 || c == 12) begin
                n_tests++;
                if (idone[4] !== (c == 12)) begin
                    n_fail++;
                    $display("FAIL clear depth12 cycle %0d: init_done=%b, need %b", c, idone[4], (c == 12));
                end
            end
        end
        for (int a = 0; a < 16; a++) begin
            set_a(1'b1, 2'b00, AW'(a), 16'h0);
            q0.push_back(16'h0);
            tick();
            begin
                logic [W-1:0] exp = q0.pop_front();
                n_tests++;
                if (douta[0] !== exp || valida[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clear readback addr %0d: douta=%h valida=%b, need %h and 1",
                             a, douta[0], valida[0], exp);
                end
            end
        end
        set_a(1'b0, 2'b00, 4'd0, 16'h0);
        tick();
    endtask

    task automatic test_byte_enable();
        logic [W-1:0] exp;
        set_a(1'b1, 2'b11, 4'd5, 16'hBEEF); tick();
        set_a(1'b1, 2'b01, 4'd5, 16'h1234); tick();
        set_a(1'b1, 2'b00, 4'd5, 16'h0);
        q0.push_back(16'hBE34);
        tick();
        exp = q0.pop_front();
        n_tests++;
        if (douta[0] !== exp || valida[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_enable: douta=%h valida=%b, need %h and 1", douta[0], valida[0], exp);
        end
        set_a(1'b0, 2'b00, 4'd0, 16'h0);
        tick();
        n_tests++;
        if (douta[0] !== exp || valida[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: douta=%h valida=%b, need %h and 0", douta[0], valida[0], exp);
        end
    endtask

    task automatic test_rdw();
        logic [W-1:0] e0, e1, e2;
        set_a(1'b1, 2'b11, 4'd9, 16'h5555); tick();
        set_a(1'b1, 2'b00, 4'd9, 16'h0); tick();
        set_a(1'b1, 2'b11, 4'd9, 16'hAAAA);
        q0.push_back(16'h5555); q1.push_back(16'hAAAA); q2.push_back(16'h5555);
        tick();
        set_a(1'b1, 2'b01, 4'd9, 16'h1234);
        q0.push_back(16'hAAAA); q1.push_back(16'hAA34); q2.push_back(16'h5555);
        for (int s = 0; s < 2; s++) begin
            e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
            n_tests++;
            if (douta[0] !== e0 || valida[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL rdw_read_first step %0d: douta=%h valida=%b, need %h and 1", s, douta[0], valida[0], e0);
            end
            n_tests++;
            if (douta[1] !== e1 || valida[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL rdw_write_first step %0d: douta=%h valida=%b, need %h and 1", s, douta[1], valida[1], e1);
            end
            n_tests++;
            if (douta[2] !== e2 || valida[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL rdw_no_change step %0d: douta=%h valida=%b, need %h and 0", s, douta[2], valida[2], e2);
            end
            if (s == 0) tick();
        end
        tick();
        set_a(1'b0, 2'b00, 4'd0, 16'h0);
        tick();
    endtask

    task automatic test_collision();
        logic [W-1:0] ea, eb;
        set_a(1'b1, 2'b11, 4'd7, 16'h1111); set_b(1'b1, 2'b11, 4'd7, 16'h2222);
        tick();
        n_tests++;
        if (coll[0] !== 1'b1 || coll[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_ww: coll=%b coll_oreg=%b, need 1 and 1", coll[0], coll[3]);
        end
        set_a(1'b0, 2'b00, 4'd0, 16'h0); set_b(1'b0, 2'b00, 4'd0, 16'h0);
        tick();
        n_tests++;
        if (coll[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_pulse: coll=%b, need 0", coll[0]);
        end
        set_a(1'b1, 2'b00, 4'd7, 16'h0); set_b(1'b1, 2'b00, 4'd7, 16'h0);
        q0.push_back(16'h2222); qb.push_back(16'h2222);
        tick();
        ea = q0.pop_front(); eb = qb.pop_front();
        n_tests++;
        if (douta[0] !== ea || doutb[0] !== eb || validb[0] !== 1'b1 || coll[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_b_wins: douta=%h doutb=%h validb=%b coll=%b, need %h %h 1 0",
                     douta[0], doutb[0], validb[0], coll[0], ea, eb);
        end
        set_a(1'b1, 2'b11, 4'd7, 16'h1111); set_b(1'b1, 2'b10, 4'd7, 16'h2222);
        tick();
        set_a(1'b1, 2'b00, 4'd7, 16'h0); set_b(1'b1, 2'b11, 4'd7, 16'h3333);
        q0.push_back(16'h2211);
        tick();
        ea = q0.pop_front();
        n_tests++;
        if (douta[0] !== ea || coll[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_lane_merge/read_vs_write: douta=%h coll=%b, need %h and 1", douta[0], coll[0], ea);
        end
        set_a(1'b1, 2'b00, 4'd7, 16'h0); set_b(1'b0, 2'b00, 4'd0, 16'h0);
        q0.push_back(16'h3333);
        tick();
        ea = q0.pop_front();
        n_tests++;
        if (douta[0] !== ea) begin
            n_fail++;
            $display("FAIL collision_write_landed: douta=%h, need %h", douta[0], ea);
        end
        set_a(1'b0, 2'b00, 4'd0, 16'h0);
        tick();
    endtask

    task automatic test_out_of_range();
        logic [W-1:0] e0;
        set_a(1'b1, 2'b11, 4'd13, 16'hFFFF); set_b(1'b1, 2'b11, 4'd13, 16'h0F0F);
        tick();
        n_tests++;
        if (coll[4] !== 1'b0 || coll[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_collision: coll_depth12=%b coll_depth16=%b, need 0 and 1", coll[4], coll[0]);
        end
        set_a(1'b1, 2'b00, 4'd13, 16'h0); set_b(1'b0, 2'b00, 4'd0, 16'h0);
        q0.push_back(16'h0F0F);
        tick();
        e0 = q0.pop_front();
        n_tests++;
        if (douta[4] !== 16'h0 || valida[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read: douta=%h valida=%b, need 0000 and 1", douta[4], valida[4]);
        end
        n_tests++;
        if (douta[0] !== e0) begin
            n_fail++;
            $display("FAIL oor_inrange_ref: douta=%h, need %h", douta[0], e0);
        end
        set_a(1'b1, 2'b11, 4'd11, 16'hC0DE); tick();
        set_a(1'b1, 2'b00, 4'd11, 16'h0); tick();
        n_tests++;
        if (douta[4] !== 16'hC0DE || valida[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL last_addr: douta=%h valida=%b, need c0de and 1", douta[4], valida[4]);
        end
        set_a(1'b0, 2'b00, 4'd0, 16'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 2'b11, AW'(i), 16'(10 + i));
            tick();
        end
        set_a(1'b0, 2'b00, 4'd0, 16'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                set_a(1'b1, 2'b00, AW'(i), 16'h0);
                q3.push_back(16'(10 + i));
            end else begin
                set_a(1'b0, 2'b00, 4'd0, 16'h0);
            end
            tick();
            n_tests++;
            if (i == 0 || i == 5) begin
                if (valida[3] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL oreg_bubble cycle %0d: valida=%b, need 0", i, valida[3]);
                end
            end else begin
                e = q3.pop_front();
                if (douta[3] !== e || valida[3] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL oreg_stream cycle %0d: douta=%0d valida=%b, need %0d and 1",
                             i, douta[3], valida[3], e);
                end
            end
        end
    endtask

    task automatic test_reset_midsweep();
        logic [W-1:0] e;
        set_a(1'b1, 2'b00, 4'd2, 16'h0);
        tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (douta[3] !== 16'h0 || valida[3] !== 1'b0 || douta[0] !== 16'h0 || idone[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: douta_oreg=%h valida_oreg=%b douta=%h init_done=%b, need 0 0 0 0",
                     douta[3], valida[3], douta[0], idone[0]);
        end
        tick();
        rst_n = 1'b1;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (idone[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_reset: init_done=%b, need 0", idone[0]);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            n_tests++;
            if (idone[0] !== (c == 16) || valida[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL resweep cycle %0d: init_done=%b valida=%b, need %b and 0",
                         c, idone[0], valida[0], (c == 16));
            end
        end
        set_a(1'b1, 2'b00, 4'd5, 16'h0);
        q0.push_back(16'h0);
        tick();
        e = q0.pop_front();
        n_tests++;
        if (douta[0] !== e || valida[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL resweep_cleared: douta=%h valida=%b, need %h and 1", douta[0], valida[0], e);
        end
        set_a(1'b0, 2'b00, 4'd0, 16'h0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear();
        test_byte_enable();
        test_rdw();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_reset_midsweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
